// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider with tick strobes
//
// Generates NUM_CH independent divided clocks from clk_in. Each channel has a
// shadow config (div/high) written through cfg_*; it is copied into the active
// config only at period boundaries, so rate changes never produce glitches.
//
// Ports:
//   clk_in    source clock, all logic on its rising edge
//   rst       synchronous active-high reset
//   cfg_we    shadow config write strobe for channel cfg_ch
//   cfg_ch    target channel (values >= NUM_CH are ignored)
//   cfg_div   period in clk_in cycles (clamped to >= 2 at load)
//   cfg_high  high cycles per period (clamped to 1..N-1 at load)
//   ch_en     per-channel run request (level)
//   sync_req  one-cycle pulse restarting all running channels in phase
//   clk_out   registered divided clocks
//   tick      one-cycle strobe on the first high cycle of each period
//   busy      channel running
module clk_div_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q  [NUM_CH];
    logic [CNT_W-1:0]   div_s_q  [NUM_CH];
    logic [CNT_W-1:0]   high_s_q [NUM_CH];
    logic [CNT_W-1:0]   div_a_q  [NUM_CH];
    logic [CNT_W-1:0]   high_a_q [NUM_CH];
    logic [CNT_W-1:0]   cnt_q    [NUM_CH];
    logic [NUM_CH-1:0]  clk_out_q;
    logic [NUM_CH-1:0]  tick_q;

    // Period is at least 2 so there is always both a high and a low cycle.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

    // High phase is forced into 1..N-1 so clk_out always toggles.
    function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] d,
                                                    input logic [CNT_W-1:0] h);
        logic [CNT_W-1:0] n;
        logic [CNT_W-1:0] hh;
        n  = clamp_div(d);
        hh = (h == '0) ? CNT_W'(1) : h;
        if (hh > n - CNT_W'(1)) begin
            hh = n - CNT_W'(1);
        end
        return hh;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]   <= ST_IDLE;
                cnt_q[i]     <= '0;
                clk_out_q[i] <= 1'b0;
                tick_q[i]    <= 1'b0;
                div_s_q[i]   <= CNT_W'(DEF_DIV);
                high_s_q[i]  <= CNT_W'(DEF_HIGH);
                div_a_q[i]   <= clamp_div(CNT_W'(DEF_DIV));
                high_a_q[i]  <= clamp_high(CNT_W'(DEF_DIV), CNT_W'(DEF_HIGH));
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Shadow update; a reload on this same edge still sees the old
                // shadow value because of non-blocking semantics.
                if (cfg_we && (cfg_ch == CH_W'(i))) begin
                    div_s_q[i]  <= cfg_div;
                    high_s_q[i] <= cfg_high;
                end

                case (state_q[i])
                    ST_IDLE: begin
                        if (ch_en[i]) begin
                            state_q[i]   <= ST_RUN;
                            div_a_q[i]   <= clamp_div(div_s_q[i]);
                            high_a_q[i]  <= clamp_high(div_s_q[i], high_s_q[i]);
                            cnt_q[i]     <= '0;
                            clk_out_q[i] <= 1'b1;
                            tick_q[i]    <= 1'b1;
                        end else begin
                            clk_out_q[i] <= 1'b0;
                            tick_q[i]    <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        // sync_req forces an early boundary on every running channel.
                        if (sync_req || (cnt_q[i] == div_a_q[i] - CNT_W'(1))) begin
                            cnt_q[i] <= '0;
                            if (ch_en[i]) begin
                                div_a_q[i]   <= clamp_div(div_s_q[i]);
                                high_a_q[i]  <= clamp_high(div_s_q[i], high_s_q[i]);
                                clk_out_q[i] <= 1'b1;
                                tick_q[i]    <= 1'b1;
                            end else begin
                                state_q[i]   <= ST_IDLE;
                                clk_out_q[i] <= 1'b0;
                                tick_q[i]    <= 1'b0;
                            end
                        end else begin
                            // ch_en is ignored mid-period, so a brief drop is seamless.
                            cnt_q[i]     <= cnt_q[i] + CNT_W'(1);
                            clk_out_q[i] <= ((cnt_q[i] + CNT_W'(1)) < high_a_q[i]);
                            tick_q[i]    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            busy[i] = (state_q[i] == ST_RUN);
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
module tb_clk_div_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_high;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_req;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    clk_div_multi #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .DEF_DIV  (2),
        .DEF_HIGH (1)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_high (cfg_high),
        .ch_en    (ch_en),
        .sync_req (sync_req),
        .clk_out  (clk_out),
        .tick     (tick),
        .busy     (busy)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_div  = '0;
        cfg_high = '0;
        ch_en    = '0;
        sync_req = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int d, input int h);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_div  = CNT_W'(d);
        cfg_high = CNT_W'(h);
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (clk_out !== 4'b0000) begin fails++; $display("FAIL reset_clk_out got=%b exp=0000", clk_out); end
        tests++;
        if (tick !== 4'b0000) begin fails++; $display("FAIL reset_tick got=%b exp=0000", tick); end
        tests++;
        if (busy !== 4'b0000) begin fails++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    endtask

    task automatic test_default();
        logic [3:0] e;
        do_reset();
        ch_en = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            step();
            e = (k % 2 == 0) ? 4'b0001 : 4'b0000;
            tests++;
            if (clk_out !== e) begin fails++; $display("FAIL default_clk k=%0d got=%b exp=%b", k, clk_out, e); end
            tests++;
            if (tick !== e) begin fails++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick, e); end
            tests++;
            if (busy !== 4'b0001) begin fails++; $display("FAIL default_busy k=%0d got=%b exp=0001", k, busy); end
        end
    endtask

    task automatic test_div5();
        logic [3:0] ec, et;
        do_reset();
        write_cfg(1, 5, 2);
        tests++;
        if (busy !== 4'b0000) begin fails++; $display("FAIL div5_idle_after_write got=%b exp=0000", busy); end
        ch_en = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            step();
            ec = ((k % 5) < 2) ? 4'b0010 : 4'b0000;
            et = ((k % 5) == 0) ? 4'b0010 : 4'b0000;
            tests++;
            if (clk_out !== ec) begin fails++; $display("FAIL div5_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
            tests++;
            if (tick !== et) begin fails++; $display("FAIL div5_tick k=%0d got=%b exp=%b", k, tick, et); end
            tests++;
            if (busy !== 4'b0010) begin fails++; $display("FAIL div5_busy k=%0d got=%b exp=0010", k, busy); end
        end
    endtask

    task automatic test_cfg_update();
        logic [0:18] exp_c;
        logic [0:18] exp_t;
        exp_c = 19'b1100010010010011001;
        exp_t = 19'b1000010010010010001;
        do_reset();
        write_cfg(1, 5, 2);
        ch_en = 4'b0010;
        for (int k = 0; k < 19; k++) begin
            if (k == 2) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = CNT_W'(3); cfg_high = CNT_W'(1);
            end else if (k == 11) begin
                cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = CNT_W'(4); cfg_high = CNT_W'(2);
            end else begin
                cfg_we = 1'b0;
            end
            step();
            tests++;
            if (clk_out[1] !== exp_c[k]) begin fails++; $display("FAIL cfg_update_clk k=%0d got=%b exp=%b", k, clk_out[1], exp_c[k]); end
            tests++;
            if (tick[1] !== exp_t[k]) begin fails++; $display("FAIL cfg_update_tick k=%0d got=%b exp=%b", k, tick[1], exp_t[k]); end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_clamp();
        logic [3:0] ec, et;
        do_reset();
        write_cfg(0, 0, 0);
        write_cfg(2, 4, 9);
        ch_en = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            step();
            ec = {1'b0, ((k % 4) < 3), 1'b0, ((k % 2) == 0)};
            et = {1'b0, ((k % 4) == 0), 1'b0, ((k % 2) == 0)};
            tests++;
            if (clk_out !== ec) begin fails++; $display("FAIL clamp_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
            tests++;
            if (tick !== et) begin fails++; $display("FAIL clamp_tick k=%0d got=%b exp=%b", k, tick, et); end
        end
    endtask

    task automatic test_graceful_stop();
        logic [3:0] ec, et, eb;
        do_reset();
        write_cfg(0, 4, 2);
        write_cfg(2, 6, 3);
        for (int k = 0; k < 8; k++) begin
            ch_en[0] = (k != 2);
            ch_en[2] = (k < 2);
            step();
            ec = {1'b0, (k < 3), 1'b0, ((k % 4) < 2)};
            et = {1'b0, (k == 0), 1'b0, ((k % 4) == 0)};
            eb = {1'b0, (k < 6), 1'b0, 1'b1};
            tests++;
            if (clk_out !== ec) begin fails++; $display("FAIL stop_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
            tests++;
            if (tick !== et) begin fails++; $display("FAIL stop_tick k=%0d got=%b exp=%b", k, tick, et); end
            tests++;
            if (busy !== eb) begin fails++; $display("FAIL stop_busy k=%0d got=%b exp=%b", k, busy, eb); end
        end
    endtask

    task automatic test_sync_and_rst();
        logic [3:0] ec, et;
        do_reset();
        write_cfg(0, 4, 2);
        write_cfg(2, 6, 3);
        ch_en = 4'b0101;
        for (int k = 0; k < 3; k++) step();
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        tests++;
        if (clk_out !== 4'b0101) begin fails++; $display("FAIL sync_clk got=%b exp=0101", clk_out); end
        tests++;
        if (tick !== 4'b0101) begin fails++; $display("FAIL sync_tick got=%b exp=0101", tick); end
        tests++;
        if (busy !== 4'b0101) begin fails++; $display("FAIL sync_busy got=%b exp=0101", busy); end
        for (int j = 1; j < 6; j++) begin
            step();
            ec = {1'b0, ((j % 6) < 3), 1'b0, ((j % 4) < 2)};
            et = {1'b0, ((j % 6) == 0), 1'b0, ((j % 4) == 0)};
            tests++;
            if (clk_out !== ec) begin fails++; $display("FAIL post_sync_clk j=%0d got=%b exp=%b", j, clk_out, ec); end
            tests++;
            if (tick !== et) begin fails++; $display("FAIL post_sync_tick j=%0d got=%b exp=%b", j, tick, et); end
        end
        ch_en = 4'b0100;
        sync_req = 1'b1;
        step();
        sync_req = 1'b0;
        tests++;
        if (busy !== 4'b0100) begin fails++; $display("FAIL sync_disabled_busy got=%b exp=0100", busy); end
        tests++;
        if (clk_out !== 4'b0100) begin fails++; $display("FAIL sync_disabled_clk got=%b exp=0100", clk_out); end
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (clk_out !== 4'b0000) begin fails++; $display("FAIL midrun_rst_clk got=%b exp=0000", clk_out); end
        tests++;
        if (tick !== 4'b0000) begin fails++; $display("FAIL midrun_rst_tick got=%b exp=0000", tick); end
        tests++;
        if (busy !== 4'b0000) begin fails++; $display("FAIL midrun_rst_busy got=%b exp=0000", busy); end
        for (int k = 0; k < 4; k++) begin
            step();
            ec = ((k % 2) == 0) ? 4'b0100 : 4'b0000;
            tests++;
            if (clk_out !== ec) begin fails++; $display("FAIL rst_defaults_clk k=%0d got=%b exp=%b", k, clk_out, ec); end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_div5();
        test_cfg_update();
        test_clamp();
        test_graceful_stop();
        test_sync_and_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1);
    end

endmodule
